mpu_store_stream: RTL and testbench

MPU_STORE_STREAM -- requirements
Module: mpu_store_stream

---
 rtl/mpu_store_stream.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mpu_store_stream.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_store_stream.sv
// mpu_store_stream
//   Streams an m x n matrix from a register file to memory. Reads are issued
//   to the register file in traversal order. The one-cycle-latency read data
//   goes into a 2-entry FIFO, and the FIFO head drives a valid/ready store
//   port.
//
// Optional feature (macro MPU_STORE_TRANSPOSE_EN):
//   Adds transpose_in, which is captured at start. When it is set, the matrix
//   is traversed column-major and mem_m_size_out/mem_n_size_out are swapped.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   store_en_in              start pulse (sampled only while idle)
//   m_size_in, n_size_in     row/column counts, captured on accepted start
//   transpose_in             (macro only) column-major traversal select
//   reg_rd_en_out            register-file read strobe
//   reg_i_out, reg_j_out     register-file read row/column
//   reg_element_in           read data, valid one cycle after the strobe
//   mem_store_valid_out      element valid to memory
//   mem_store_ready_in       memory accepts element
//   mem_store_element_out    element data
//   mem_i_out, mem_j_out     element location
//   mem_m_size_out, mem_n_size_out  captured sizes
//   mem_last_out             final element of the matrix
//   busy_out                 high outside IDLE
//   done_out                 one-cycle pulse after the last element is accepted
//   size_err_out             one-cycle pulse on a start with a zero size
module mpu_store_stream #(
  parameter int unsigned FP    = 32,
  parameter int unsigned MBITS = 3,
  parameter int unsigned NBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_en_in,
  input  logic [MBITS:0]   m_size_in,
  input  logic [NBITS:0]   n_size_in,
`ifdef MPU_STORE_TRANSPOSE_EN
  input  logic             transpose_in,
`endif
  output logic             reg_rd_en_out,
  output logic [MBITS:0]   reg_i_out,
  output logic [NBITS:0]   reg_j_out,
  input  logic [FP-1:0]    reg_element_in,
  output logic             mem_store_valid_out,
  input  logic             mem_store_ready_in,
  output logic [FP-1:0]    mem_store_element_out,
  output logic [MBITS:0]   mem_i_out,
  output logic [NBITS:0]   mem_j_out,
  output logic [MBITS:0]   mem_m_size_out,
  output logic [NBITS:0]   mem_n_size_out,
  output logic             mem_last_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             size_err_out
);

  localparam int unsigned MW = MBITS + 1;
  localparam int unsigned NW = NBITS + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [FP-1:0] data;
    logic [MW-1:0] i;
    logic [NW-1:0] j;
    logic          last;
  } entry_t;

  state_e        state_q, state_d;
  logic [MW-1:0] m_q, m_d, msz_q, msz_d, rd_i_q, rd_i_d, infl_i_q, infl_i_d;
  logic [NW-1:0] n_q, n_d, nsz_q, nsz_d, rd_j_q, rd_j_d, infl_j_q, infl_j_d;
  logic          infl_q, infl_d, infl_last_q, infl_last_d;
  logic          done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic          col_major;

  entry_t        fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q;
  entry_t        head, push_entry;
  logic          pop, rd_go, rd_last, last_i, last_j;
  logic [1:0]    credit;

`ifdef MPU_STORE_TRANSPOSE_EN
  logic tr_q, tr_d;
  assign col_major = tr_q;
`else
  assign col_major = 1'b0;
`endif

  // FIFO head/push data, handshake and read-issue decision
  always_comb begin
    head            = fifo_q[rd_ptr_q];
    push_entry.data = reg_element_in;
    push_entry.i    = infl_i_q;
    push_entry.j    = infl_j_q;
    push_entry.last = infl_last_q;
    pop             = (cnt_q != 2'd0) && mem_store_ready_in;
    // Count the entry leaving this cycle as freed. Without that, a 2-deep
    // FIFO with a one-cycle read latency could only sustain half rate.
    credit          = cnt_q + 2'(infl_q) - 2'(pop);
    last_i          = (rd_i_q == m_q - MW'(1));
    last_j          = (rd_j_q == n_q - NW'(1));
    rd_last         = last_i && last_j;
    rd_go           = (state_q == STREAM) && (credit < 2'd2);
  end

  // Next-state, traversal counters and pulse outputs
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    msz_d       = msz_q;
    nsz_d       = nsz_q;
    rd_i_d      = rd_i_q;
    rd_j_d      = rd_j_q;
    infl_d      = rd_go;
    infl_i_d    = rd_i_q;
    infl_j_d    = rd_j_q;
    infl_last_d = rd_last;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef MPU_STORE_TRANSPOSE_EN
    tr_d        = tr_q;
`endif
    case (state_q)
      IDLE: begin
        if (store_en_in) begin
          if ((m_size_in == '0) || (n_size_in == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d = STREAM;
            m_d     = m_size_in;
            n_d     = n_size_in;
            rd_i_d  = '0;
            rd_j_d  = '0;
`ifdef MPU_STORE_TRANSPOSE_EN
            tr_d    = transpose_in;
            msz_d   = transpose_in ? MW'(n_size_in) : m_size_in;
            nsz_d   = transpose_in ? NW'(m_size_in) : n_size_in;
`else
            msz_d   = m_size_in;
            nsz_d   = n_size_in;
`endif
          end
        end
      end
      STREAM: begin
        if (rd_go) begin
          if (rd_last) begin
            state_d = DRAIN;
          end else if (col_major) begin
            if (last_i) begin
              rd_i_d = '0;
              rd_j_d = rd_j_q + NW'(1);
            end else begin
              rd_i_d = rd_i_q + MW'(1);
            end
          end else begin
            if (last_j) begin
              rd_j_d = '0;
              rd_i_d = rd_i_q + MW'(1);
            end else begin
              rd_j_d = rd_j_q + NW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and traversal registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      n_q         <= '0;
      msz_q       <= '0;
      nsz_q       <= '0;
      rd_i_q      <= '0;
      rd_j_q      <= '0;
      infl_q      <= 1'b0;
      infl_i_q    <= '0;
      infl_j_q    <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MPU_STORE_TRANSPOSE_EN
      tr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      msz_q       <= msz_d;
      nsz_q       <= nsz_d;
      rd_i_q      <= rd_i_d;
      rd_j_q      <= rd_j_d;
      infl_q      <= infl_d;
      infl_i_q    <= infl_i_d;
      infl_j_q    <= infl_j_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef MPU_STORE_TRANSPOSE_EN
      tr_q        <= tr_d;
`endif
    end
  end

  // 2-entry output FIFO; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (infl_q) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
    end
  end

  // The read strobe is decoded from registered state and ready, so an issued
  // read always has a FIFO slot waiting for its data.
  assign reg_rd_en_out         = rd_go;
  assign reg_i_out             = rd_i_q;
  assign reg_j_out             = rd_j_q;
  assign mem_store_valid_out   = (cnt_q != 2'd0);
  assign mem_store_element_out = head.data;
  assign mem_i_out             = head.i;
  assign mem_j_out             = head.j;
  assign mem_last_out          = head.last;
  assign mem_m_size_out        = msz_q;
  assign mem_n_size_out        = nsz_q;
  assign busy_out              = busy_q;
  assign done_out              = done_q;
  assign size_err_out          = err_q;

endmodule

// File: tb/tb_mpu_store_stream.sv
// tb_mpu_store_stream
//   Directed bench for mpu_store_stream with default parameters (FP=32,
//   4-bit indices). A behavioural register file answers reads one cycle
//   later with data derived from (i,j). A negedge monitor logs every memory
//   transfer with its cycle number.
//   Define MPU_STORE_TRANSPOSE_EN to connect and exercise transpose_in.
module tb_mpu_store_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store_en_in = 1'b0;
  logic [3:0]  m_size_in = 4'd0;
  logic [3:0]  n_size_in = 4'd0;
`ifdef MPU_STORE_TRANSPOSE_EN
  logic        transpose_in = 1'b0;
`endif
  logic        reg_rd_en_out;
  logic [3:0]  reg_i_out, reg_j_out;
  logic [31:0] reg_element_in = 32'h0;
  logic        mem_store_valid_out;
  logic        mem_store_ready_in = 1'b1;
  logic [31:0] mem_store_element_out;
  logic [3:0]  mem_i_out, mem_j_out, mem_m_size_out, mem_n_size_out;
  logic        mem_last_out, busy_out, done_out, size_err_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int rd_cnt = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int hold_viol = 0, hold_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] h_data;
  logic [3:0]  h_i, h_j;
  logic        h_last, done_busy;
  int          q_i[$], q_j[$], q_c[$];
  logic [31:0] q_d[$];
  logic        q_l[$];

  mpu_store_stream dut (
    .clk                   (clk),
    .rst                   (rst),
    .store_en_in           (store_en_in),
    .m_size_in             (m_size_in),
    .n_size_in             (n_size_in),
`ifdef MPU_STORE_TRANSPOSE_EN
    .transpose_in          (transpose_in),
`endif
    .reg_rd_en_out         (reg_rd_en_out),
    .reg_i_out             (reg_i_out),
    .reg_j_out             (reg_j_out),
    .reg_element_in        (reg_element_in),
    .mem_store_valid_out   (mem_store_valid_out),
    .mem_store_ready_in    (mem_store_ready_in),
    .mem_store_element_out (mem_store_element_out),
    .mem_i_out             (mem_i_out),
    .mem_j_out             (mem_j_out),
    .mem_m_size_out        (mem_m_size_out),
    .mem_n_size_out        (mem_n_size_out),
    .mem_last_out          (mem_last_out),
    .busy_out              (busy_out),
    .done_out              (done_out),
    .size_err_out          (size_err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_data(input int i, input int j);
    return 32'h5A00_0000 | 32'(i << 8) | 32'(j);
  endfunction

  // Register file: a read seen in one cycle returns its data in the next
  always begin : regfile
    logic rq;
    int   ri, rj;
    @(negedge clk);
    rq = reg_rd_en_out;
    ri = int'(reg_i_out);
    rj = int'(reg_j_out);
    @(posedge clk);
    #1;
    reg_element_in = rq ? exp_data(ri, rj) : 32'hDEAD_BEEF;
  end

  // Monitor: transfers, pulses, read count and stability under backpressure
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (reg_rd_en_out) rd_cnt++;
      if (done_out) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy_out;
      end
      if (size_err_out) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (hold_pend && (!mem_store_valid_out || mem_store_element_out !== h_data ||
                        mem_i_out !== h_i || mem_j_out !== h_j || mem_last_out !== h_last))
        hold_viol++;
      hold_pend = mem_store_valid_out && !mem_store_ready_in;
      if (hold_pend) hold_cnt++;
      h_data = mem_store_element_out;
      h_i    = mem_i_out;
      h_j    = mem_j_out;
      h_last = mem_last_out;
      if (mem_store_valid_out && mem_store_ready_in) begin
        q_i.push_back(int'(mem_i_out));
        q_j.push_back(int'(mem_j_out));
        q_d.push_back(mem_store_element_out);
        q_l.push_back(mem_last_out);
        q_c.push_back(cyc);
      end
    end
  end

  task automatic do_start(input int m, input int n, output int acc);
    @(posedge clk); #2;
    store_en_in = 1'b1;
    m_size_in   = 4'(m);
    n_size_in   = 4'(n);
    @(posedge clk); #2;
    acc         = cyc;
    store_en_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({mem_store_valid_out, reg_rd_en_out, busy_out, done_out, size_err_out, mem_last_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_store_valid_out, reg_rd_en_out, busy_out, done_out, size_err_out, mem_last_out});
    end
    checks++;
    if ({mem_i_out, mem_j_out, reg_i_out, reg_j_out, mem_m_size_out, mem_n_size_out} !== 24'h0) begin
      errors++;
      $display("FAIL reset_idx: got %h want 000000",
               {mem_i_out, mem_j_out, reg_i_out, reg_j_out, mem_m_size_out, mem_n_size_out});
    end
    checks++;
    if (mem_store_element_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", mem_store_element_out);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // m=2,n=3, ready high: six elements on consecutive cycles, restart ignored
  task automatic test_basic();
    int base, d0, acc;
    base = q_i.size();
    d0   = done_cnt;
    mem_store_ready_in = 1'b1;
    do_start(2, 3, acc);
    @(posedge clk); #2;
    store_en_in = 1'b1;
    m_size_in   = 4'd1;
    n_size_in   = 4'd1;
    @(posedge clk); #2;
    store_en_in = 1'b0;
    checks++;
    if (mem_m_size_out !== 4'd2 || mem_n_size_out !== 4'd3 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_sizes: got m=%0d n=%0d busy=%b want 2 3 1", mem_m_size_out, mem_n_size_out, busy_out);
    end
    for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL basic_done_timeout: got %0d want %0d", done_cnt - d0, 1);
    end
    checks++;
    if (q_i.size() - base !== 6) begin
      errors++;
      $display("FAIL basic_count: got %0d want 6", q_i.size() - base);
    end
    for (int k = 0; k < 6 && base + k < q_i.size(); k++) begin
      checks++;
      if (q_i[base+k] !== k / 3 || q_j[base+k] !== k % 3 || q_d[base+k] !== exp_data(k / 3, k % 3)) begin
        errors++;
        $display("FAIL basic_elem%0d: got (%0d,%0d) %h want (%0d,%0d) %h", k, q_i[base+k], q_j[base+k],
                 q_d[base+k], k / 3, k % 3, exp_data(k / 3, k % 3));
      end
      checks++;
      if (q_c[base+k] !== acc + 2 + k || q_l[base+k] !== (k == 5)) begin
        errors++;
        $display("FAIL basic_time%0d: got cyc=%0d last=%b want cyc=%0d last=%b", k, q_c[base+k] - acc,
                 q_l[base+k], 2 + k, (k == 5));
      end
    end
    checks++;
    if (done_cyc !== acc + 8 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_cyc: got %0d busy=%b want 8 busy=0", done_cyc - acc, done_busy);
    end
  endtask

  // m=2,n=2, ready toggling: in order, held stable while ready is low
  task automatic test_backpressure();
    int base, d0, acc, hv0, hc0;
    base = q_i.size();
    d0   = done_cnt;
    hv0  = hold_viol;
    hc0  = hold_cnt;
    mem_store_ready_in = 1'b1;
    do_start(2, 2, acc);
    for (int k = 0; k < 100 && done_cnt == d0; k++) begin
      @(posedge clk); #2;
      mem_store_ready_in = ~mem_store_ready_in;
    end
    mem_store_ready_in = 1'b1;
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL bp_done_timeout: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (q_i.size() - base !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d want 4", q_i.size() - base);
    end
    for (int k = 0; k < 4 && base + k < q_i.size(); k++) begin
      checks++;
      if (q_i[base+k] !== k / 2 || q_j[base+k] !== k % 2 || q_d[base+k] !== exp_data(k / 2, k % 2) ||
          q_l[base+k] !== (k == 3)) begin
        errors++;
        $display("FAIL bp_elem%0d: got (%0d,%0d) last=%b want (%0d,%0d) last=%b", k, q_i[base+k],
                 q_j[base+k], q_l[base+k], k / 2, k % 2, (k == 3));
      end
    end
    checks++;
    if (hold_viol !== hv0 || hold_cnt == hc0) begin
      errors++;
      $display("FAIL bp_hold: got viol=%0d stalls=%0d want viol=0 stalls>0", hold_viol - hv0, hold_cnt - hc0);
    end
  endtask

  // A zero size pulses size_err_out and never leaves IDLE
  task automatic test_size_err();
    int e0, r0, acc;
    logic bad;
    e0 = err_cnt;
    r0 = rd_cnt;
    do_start(0, 4, acc);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (busy_out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (err_cnt !== e0 + 1 || err_cyc !== acc) begin
      errors++;
      $display("FAIL size_err_pulse: got count=%0d cyc=%0d want count=1 cyc=0", err_cnt - e0, err_cyc - acc);
    end
    checks++;
    if (bad !== 1'b0 || rd_cnt !== r0) begin
      errors++;
      $display("FAIL size_err_idle: got busy_seen=%b reads=%0d want 0 0", bad, rd_cnt - r0);
    end
    do_start(3, 0, acc);
    repeat (3) @(posedge clk);
    checks++;
    if (err_cnt !== e0 + 2 || rd_cnt !== r0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL size_err_n0: got count=%0d reads=%0d busy=%b want 2 0 0", err_cnt - e0, rd_cnt - r0, busy_out);
    end
  endtask

  // m=1,n=4 with ready low for 10 cycles: only two reads may be outstanding
  task automatic test_stall();
    int base, d0, r0, hv0, acc;
    base = q_i.size();
    d0   = done_cnt;
    r0   = rd_cnt;
    hv0  = hold_viol;
    mem_store_ready_in = 1'b0;
    do_start(1, 4, acc);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (rd_cnt - r0 > 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d want <=2", rd_cnt - r0);
    end
    checks++;
    if (mem_store_valid_out !== 1'b1 || mem_i_out !== 4'd0 || mem_j_out !== 4'd0 ||
        mem_store_element_out !== exp_data(0, 0) || hold_viol !== hv0) begin
      errors++;
      $display("FAIL stall_head: got v=%b (%0d,%0d) %h viol=%0d want v=1 (0,0) %h viol=0", mem_store_valid_out,
               mem_i_out, mem_j_out, mem_store_element_out, hold_viol - hv0, exp_data(0, 0));
    end
    @(posedge clk); #2;
    mem_store_ready_in = 1'b1;
    for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || q_i.size() - base !== 4) begin
      errors++;
      $display("FAIL stall_drain: got done=%0d count=%0d want 1 4", done_cnt - d0, q_i.size() - base);
    end
    for (int k = 0; k < 4 && base + k < q_i.size(); k++) begin
      checks++;
      if (q_i[base+k] !== 0 || q_j[base+k] !== k || q_d[base+k] !== exp_data(0, k) || q_l[base+k] !== (k == 3)) begin
        errors++;
        $display("FAIL stall_elem%0d: got (%0d,%0d) last=%b want (0,%0d) last=%b", k, q_i[base+k], q_j[base+k],
                 q_l[base+k], k, (k == 3));
      end
    end
  endtask

  // Reset after four transfers of a 3x3: outputs clear at once, no done
  task automatic test_reset_mid();
    int base, d0, acc;
    base = q_i.size();
    d0   = done_cnt;
    mem_store_ready_in = 1'b1;
    do_start(3, 3, acc);
    while (cyc < acc + 5) begin
      @(posedge clk); #2;
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_store_valid_out, reg_rd_en_out, busy_out, done_out, size_err_out, mem_last_out} !== 6'b0 ||
        {mem_i_out, mem_j_out, reg_i_out, reg_j_out, mem_m_size_out, mem_n_size_out} !== 24'h0 ||
        mem_store_element_out !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ctrl=%b idx=%h data=%h want 0 0 0",
               {mem_store_valid_out, reg_rd_en_out, busy_out, done_out, size_err_out, mem_last_out},
               {mem_i_out, mem_j_out, reg_i_out, reg_j_out, mem_m_size_out, mem_n_size_out}, mem_store_element_out);
    end
    checks++;
    if (q_i.size() - base !== 4) begin
      errors++;
      $display("FAIL rstmid_count: got %0d want 4", q_i.size() - base);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    checks++;
    if (done_cnt !== d0 || q_i.size() - base !== 4) begin
      errors++;
      $display("FAIL rstmid_nodone: got done=%0d count=%0d want 0 4", done_cnt - d0, q_i.size() - base);
    end
    base = q_i.size();
    do_start(1, 2, acc);
    for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clk);
    checks++;
    if (q_i.size() - base !== 2 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL rstmid_restart_count: got count=%0d done=%0d want 2 1", q_i.size() - base, done_cnt - d0);
    end else begin
      checks++;
      if (q_i[base] !== 0 || q_j[base] !== 0 || q_i[base+1] !== 0 || q_j[base+1] !== 1 ||
          q_c[base] !== acc + 2 || q_l[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_restart: got (%0d,%0d)(%0d,%0d) cyc=%0d want (0,0)(0,1) cyc=2", q_i[base], q_j[base],
                 q_i[base+1], q_j[base+1], q_c[base] - acc);
      end
    end
  endtask

  // Full 15x15 traversal: no counter overflow, one element per cycle
  task automatic test_max();
    int base, d0, acc, bad;
    base = q_i.size();
    d0   = done_cnt;
    mem_store_ready_in = 1'b1;
    do_start(15, 15, acc);
    for (int k = 0; k < 600 && done_cnt == d0; k++) @(posedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || q_i.size() - base !== 225) begin
      errors++;
      $display("FAIL max_count: got done=%0d count=%0d want 1 225", done_cnt - d0, q_i.size() - base);
    end else begin
      bad = 0;
      for (int k = 0; k < 225; k++)
        if (q_i[base+k] !== k / 15 || q_j[base+k] !== k % 15 || q_l[base+k] !== (k == 224) ||
            q_c[base+k] !== acc + 2 + k)
          bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL max_order: got %0d bad elements want 0", bad);
      end
      checks++;
      if (done_cyc !== acc + 227) begin
        errors++;
        $display("FAIL max_done_cyc: got %0d want 227", done_cyc - acc);
      end
    end
  endtask

`ifdef MPU_STORE_TRANSPOSE_EN
  // Column-major order and swapped size outputs
  task automatic test_transpose();
    int base, d0, acc;
    int ei[6] = '{0, 1, 0, 1, 0, 1};
    int ej[6] = '{0, 0, 1, 1, 2, 2};
    base = q_i.size();
    d0   = done_cnt;
    mem_store_ready_in = 1'b1;
    transpose_in = 1'b1;
    do_start(2, 3, acc);
    transpose_in = 1'b0;
    checks++;
    if (mem_m_size_out !== 4'd3 || mem_n_size_out !== 4'd2) begin
      errors++;
      $display("FAIL tr_sizes: got %0d %0d want 3 2", mem_m_size_out, mem_n_size_out);
    end
    for (int k = 0; k < 100 && done_cnt == d0; k++) @(posedge clk);
    checks++;
    if (q_i.size() - base !== 6) begin
      errors++;
      $display("FAIL tr_count: got %0d want 6", q_i.size() - base);
    end
    for (int k = 0; k < 6 && base + k < q_i.size(); k++) begin
      checks++;
      if (q_i[base+k] !== ei[k] || q_j[base+k] !== ej[k] || q_d[base+k] !== exp_data(ei[k], ej[k]) ||
          q_l[base+k] !== (k == 5)) begin
        errors++;
        $display("FAIL tr_elem%0d: got (%0d,%0d) last=%b want (%0d,%0d) last=%b", k, q_i[base+k], q_j[base+k],
                 q_l[base+k], ei[k], ej[k], (k == 5));
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_size_err();
    test_stall();
    test_reset_mid();
    test_max();
`ifdef MPU_STORE_TRANSPOSE_EN
    test_transpose();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
